// File: rtl/snd_cmd_queue.sv
// rtl/snd_cmd_queue.sv - main-to-sound CPU command latch/FIFO with sound IRQ controller
module snd_cmd_queue #(
    parameter int DW          = 8,
    parameter int DEPTH       = 4,
    parameter int MODE        = 1,
    parameter int IRQ_ON_DATA = 1
) (
    input  logic                     clk_49m,
    input  logic                     reset,
    input  logic                     cen_wr,
    input  logic                     wr_cs,
    input  logic [DW-1:0]            din,
    input  logic                     trigger,
    input  logic                     cen_rd,
    input  logic                     rd_cs,
    input  logic                     irq_ack,
    output logic [DW-1:0]            dout,
    output logic                     n_int,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          pending_q, pending_d;
    logic          ovf_q, ovf_d;
    logic          rd_prev_q, rd_prev_d;

    logic wr_ev, trig_ev, pop_ev;
    logic do_pop, do_push, ovf_set, irq_set;

    assign wr_ev   = wr_cs & cen_wr;
    assign trig_ev = trigger & cen_wr;
    // One pop per read access: only the rising edge of rd_cs as seen on cen_rd counts.
    assign pop_ev  = cen_rd & rd_cs & ~rd_prev_q;

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        dout_d    = dout_q;
        do_pop    = 1'b0;
        do_push   = 1'b0;
        ovf_set   = 1'b0;
        irq_set   = trig_ev;
        rd_prev_d = cen_rd ? rd_cs : rd_prev_q;

        if (MODE == 0) begin
            if (wr_ev) begin
                dout_d  = din;
                count_d = CW'(1);
            end
        end else begin
            do_pop  = pop_ev & ~empty_q;
            // A simultaneous pop frees a slot, so a write on a full FIFO is still accepted.
            do_push = wr_ev & (~full_q | do_pop);
            ovf_set = wr_ev & full_q & ~do_pop;
            if (do_pop) begin
                dout_d = mem[rptr_q];
                rptr_d = rptr_q + AW'(1);
            end
            if (do_push) begin
                wptr_d = wptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
            if (IRQ_ON_DATA != 0 && cen_rd && !empty_q && !irq_ack) begin
                irq_set = 1'b1;
            end
        end

        pending_d = irq_set ? 1'b1 : (irq_ack ? 1'b0 : pending_q);
        ovf_d     = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
        full_d    = (MODE != 0) && (count_d == CW'(DEPTH));
        empty_d   = (count_d == '0);
    end

    always_ff @(posedge clk_49m or posedge reset) begin
        if (reset) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            dout_q    <= '0;
            pending_q <= 1'b0;
            ovf_q     <= 1'b0;
            rd_prev_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            dout_q    <= dout_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            rd_prev_q <= rd_prev_d;
        end
    end

    always_ff @(posedge clk_49m) begin
        if (do_push) begin
            mem[wptr_q] <= din;
        end
    end

    assign dout     = dout_q;
    assign n_int    = ~pending_q;
    assign count    = count_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_snd_cmd_queue.sv
// tb/tb_snd_cmd_queue.sv - randomized and directed check of snd_cmd_queue in FIFO and latch modes
module tb_snd_cmd_queue;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cen_wr = 0, wr_cs = 0, trigger = 0, cen_rd = 0, rd_cs = 0, irq_ack = 0, clr_ovf = 0;
    logic [7:0] din = '0;

    logic [7:0] dout1, dout0;
    logic       n_int1, n_int0, full1, full0, empty1, empty0, ovf1, ovf0;
    logic [2:0] count1, count0;

    int total = 0;
    int bad   = 0;

    // Reference state: FIFO contents as a queue, latch as a plain value.
    logic [7:0] q[$];
    logic [7:0] m_dout;
    bit         m_pend, m_ovf, m_prev;
    logic [7:0] m0_latch;
    bit         m0_has, m0_pend;

    always #5 clk = ~clk;

    snd_cmd_queue #(.DW(8), .DEPTH(D), .MODE(1), .IRQ_ON_DATA(1)) dut1 (
        .clk_49m(clk), .reset(reset), .cen_wr(cen_wr), .wr_cs(wr_cs), .din(din),
        .trigger(trigger), .cen_rd(cen_rd), .rd_cs(rd_cs), .irq_ack(irq_ack),
        .dout(dout1), .n_int(n_int1), .count(count1), .full(full1), .empty(empty1),
        .overflow(ovf1), .clr_ovf(clr_ovf));

    snd_cmd_queue #(.DW(8), .DEPTH(D), .MODE(0), .IRQ_ON_DATA(1)) dut0 (
        .clk_49m(clk), .reset(reset), .cen_wr(cen_wr), .wr_cs(wr_cs), .din(din),
        .trigger(trigger), .cen_rd(cen_rd), .rd_cs(rd_cs), .irq_ack(irq_ack),
        .dout(dout0), .n_int(n_int0), .count(count0), .full(full0), .empty(empty0),
        .overflow(ovf0), .clr_ovf(clr_ovf));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0; m_pend = 0; m_ovf = 0; m_prev = 0;
        m0_latch = '0; m0_has = 0; m0_pend = 0;
    endtask

    task automatic model_update();
        bit wr, trg, pop, set, ovfset;
        int n;
        wr  = cen_wr && wr_cs;
        trg = cen_wr && trigger;
        pop = cen_rd && rd_cs && !m_prev;
        if (cen_rd) m_prev = rd_cs;
        n   = q.size();
        set = trg || (cen_rd && n > 0 && !irq_ack);
        ovfset = 0;
        if (pop && n > 0) m_dout = q.pop_front();
        if (wr) begin
            if (q.size() < D) q.push_back(din);
            else ovfset = 1;
        end
        m_ovf  = ovfset ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf);
        m_pend = set ? 1'b1 : (irq_ack ? 1'b0 : m_pend);
        if (wr) begin
            m0_latch = din;
            m0_has   = 1;
        end
        m0_pend = trg ? 1'b1 : (irq_ack ? 1'b0 : m0_pend);
    endtask

    task automatic compare_all();
        chk("fifo_count", count1, q.size());
        chk("fifo_full", full1, q.size() == D);
        chk("fifo_empty", empty1, q.size() == 0);
        chk("fifo_dout", dout1, m_dout);
        chk("fifo_n_int", n_int1, !m_pend);
        chk("fifo_ovf", ovf1, m_ovf);
        chk("latch_count", count0, m0_has);
        chk("latch_full", full0, 0);
        chk("latch_empty", empty0, !m0_has);
        chk("latch_dout", dout0, m0_latch);
        chk("latch_n_int", n_int0, !m0_pend);
        chk("latch_ovf", ovf0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_update();
        compare_all();
    endtask

    task automatic clr();
        cen_wr = 0; wr_cs = 0; trigger = 0; cen_rd = 0; rd_cs = 0; irq_ack = 0; clr_ovf = 0;
    endtask

    task automatic wr(input logic [7:0] d);
        clr(); cen_wr = 1; wr_cs = 1; din = d; step(); clr();
    endtask

    task automatic trig();
        clr(); cen_wr = 1; trigger = 1; step(); clr();
    endtask

    task automatic ack();
        clr(); irq_ack = 1; step(); clr();
    endtask

    task automatic tick_rd();
        clr(); cen_rd = 1; step(); clr();
    endtask

    task automatic rd();
        clr(); rd_cs = 1; cen_rd = 1; step();
        cen_rd = 0; step();
        rd_cs = 0; cen_rd = 1; step(); clr();
    endtask

    task automatic push_pop(input logic [7:0] d);
        clr(); rd_cs = 1; cen_rd = 1; wr_cs = 1; cen_wr = 1; din = d; step();
        clr(); cen_rd = 1; step(); clr();
    endtask

    task automatic rand_phase(input int cycles, input int wp, input int rp);
        for (int i = 0; i < cycles; i++) begin
            cen_wr  = ($urandom % 3) == 0;
            wr_cs   = ($urandom % 100) < wp;
            din     = 8'($urandom);
            trigger = ($urandom % 16) == 0;
            cen_rd  = ($urandom % 3) == 0;
            if (($urandom % 100) < rp) rd_cs = !rd_cs;
            irq_ack = ($urandom % 8) == 0;
            clr_ovf = ($urandom % 20) == 0;
            step();
        end
        clr();
    endtask

    initial begin
        logic [7:0] v;
        clr();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        compare_all();
        chk("reset_n_int", n_int1, 1);
        chk("reset_empty", empty1, 1);
        reset = 0;

        // Latch mode plan; the FIFO instance sees the same traffic.
        wr(8'h12); wr(8'h34); trig();
        chk("m0_dout_last", dout0, 8'h34);
        chk("m0_irq_on", n_int0, 0);
        ack();
        chk("m0_irq_off", n_int0, 1);
        for (int i = 0; i < 3; i++) begin
            rd();
            chk("m0_read_keeps", dout0, 8'h34);
        end
        chk("fifo_after_extra_read", dout1, 8'h34);

        // Fill and drain four entries.
        for (int i = 0; i < 4; i++) wr(8'hA1 + 8'(i));
        chk("fill_full", full1, 1);
        chk("fill_count", count1, 4);
        tick_rd();
        chk("fill_irq", n_int1, 0);
        for (int i = 0; i < 4; i++) begin
            rd();
            v = 8'hA1 + 8'(i);
            chk("drain_order", dout1, v);
        end
        chk("drain_empty", empty1, 1);
        rd();
        chk("empty_read_holds", dout1, 8'hA4);

        // Overflow
        for (int i = 0; i < 4; i++) wr(8'hB0 + 8'(i));
        wr(8'h55);
        chk("ovf_set", ovf1, 1);
        chk("ovf_count", count1, 4);
        clr(); clr_ovf = 1; step(); clr();
        chk("ovf_clear", ovf1, 0);
        for (int i = 0; i < 4; i++) begin
            rd();
            v = 8'hB0 + 8'(i);
            chk("ovf_drop", dout1, v);
        end

        // Pointer wrap with paired push/pop
        wr(8'hC0);
        for (int i = 1; i <= 6; i++) begin
            push_pop(8'hC0 + 8'(i));
            chk("wrap_count", count1, 1);
            v = 8'hC0 + 8'(i - 1);
            chk("wrap_order", dout1, v);
        end
        rd();
        chk("wrap_last", dout1, 8'hC6);

        // Push and pop together while full
        for (int i = 0; i < 4; i++) wr(8'hD0 + 8'(i));
        push_pop(8'hD4);
        chk("full_pp_ovf", ovf1, 0);
        chk("full_pp_count", count1, 4);
        chk("full_pp_dout", dout1, 8'hD0);

        // Long read hold yields one pop
        rd();
        clr(); rd_cs = 1;
        for (int p = 0; p < 10; p++) begin
            cen_rd = 1; step();
            cen_rd = 0; step(); step(); step();
        end
        chk("hold_count", count1, 2);
        chk("hold_dout", dout1, 8'hD2);
        tick_rd();

        // IRQ_ON_DATA re-assertion after ack
        ack();
        chk("ack_clears", n_int1, 1);
        tick_rd();
        chk("irq_reassert", n_int1, 0);
        rd(); rd();
        ack();
        tick_rd();
        chk("irq_idle_empty", n_int1, 1);

        // Asynchronous reset mid-operation
        wr(8'hE1); wr(8'hE2); wr(8'hE3);
        tick_rd();
        chk("pre_rst_count", count1, 3);
        chk("pre_rst_irq", n_int1, 0);
        #2 reset = 1;
        #1;
        model_reset();
        compare_all();
        chk("rst_count", count1, 0);
        chk("rst_n_int", n_int1, 1);
        chk("rst_dout", dout1, 0);
        #1 reset = 0;
        wr(8'h5A);
        rd();
        chk("post_rst_read", dout1, 8'h5A);

        rand_phase(600, 80, 20);
        rand_phase(600, 20, 60);
        rand_phase(600, 50, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
